pmem_burst_responder: RTL and testbench
=======================================

# pmem_burst_responder

Memory-side responder for the CPU's physical-memory burst port (pmem_read/pmem_write/pmem_addr/pmem_wdata/pmem_rdata/pmem_resp). It accepts one cache-line request at a time and, after a fixed access latency, transfers the line as a 4-beat burst of 64-bit words from or into an internal line-organized store. It is the synthesizable counterpart to the CPU's cacheline adaptor and is used in emulation builds and in block-level tests of the cache hierarchy.

## Interface

Parameters:
- DATA_W, 64, beat width in bits.
- BURST_LEN, 4, beats per line (line = 32 bytes).
- DEPTH_LINES, 256, lines in the store (power of two).
- LATENCY, 4, cycles from request acceptance to first resp beat (>= 1).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_read  in  1  read request, held by initiator until burst done.
- mem_write  in  1  write request, held by initiator until burst done.
- mem_addr  in  32  byte address; bits [4:0] ignored.
- mem_wdata  in  DATA_W  write beat, valid in cycles with mem_resp=1.
- mem_rdata  out  DATA_W  read beat, valid in cycles with mem_resp=1, else 0.
- mem_resp  out  1  beat strobe, high for BURST_LEN consecutive cycles per request.
- protocol_err  out  1  one-cycle pulse on protocol violation.

## Operation

- Store: DEPTH_LINES*BURST_LEN words of DATA_W; word index = {line_idx, beat}, line_idx = mem_addr[5+log2(DEPTH_LINES)-1:5]. Upper address bits ignored (aliasing wrap). Contents not reset.
- Beat k carries line bytes 8k..8k+7, k = 0..3 in order.
- FSM states: IDLE, WAIT, BURST, DONE.
  - IDLE: if mem_read or mem_write at edge, latch line_idx and op, load latency counter, go WAIT (go BURST directly if LATENCY=1).
  - WAIT: count down; at end go BURST with beat counter 0.
  - BURST: mem_resp=1 each cycle. Read: mem_rdata = store[{idx,beat}]. Write: store[{idx,beat}] <= mem_wdata at the edge ending that cycle. Beat counter increments; after beat BURST_LEN-1 go DONE.
  - DONE: one cycle, mem_resp=0, requests ignored; go IDLE.
- Both mem_read and mem_write high in IDLE: treated as read, protocol_err pulses.
- Request deasserted while in WAIT or BURST: protocol_err pulses once per request; burst still completes unchanged.
- mem_addr/op changes after acceptance are ignored (latched).

## Timing

- Reset (rst=0, any time): state IDLE, counters 0, mem_resp=0, mem_rdata=0, protocol_err=0, asynchronously. Burst in progress aborted; write beats already committed remain.
- Request sampled at edge t0 in IDLE -> mem_resp high in cycles t0+LATENCY .. t0+LATENCY+3, low at t0+LATENCY+4 (DONE), IDLE re-entered at edge ending DONE; a still-asserted request is accepted as new at the next IDLE edge (back-to-back spacing = LATENCY+5 cycles minimum).
- Read data available combinationally-free: mem_rdata registered, changes only at edges, valid throughout each resp cycle.
- Write beat k is captured at the rising edge that ends the kth resp cycle; read-after-write to the same line sees new data.
- protocol_err is registered, high exactly one cycle after the offending edge.

## Test plan

- Write line at 0x0000_0040 with beats 0x1111…1, 0x2222…2, 0x3333…3, 0x4444…4 -> resp high 4 cycles starting LATENCY=4 cycles after request; then read 0x0000_0040 returns same 4 beats in order.
- Reset value check: rst low mid-BURST of a read after beat 1 -> mem_resp and mem_rdata 0 immediately; after release a read of a line previously written returns beats 0,1 old-or-new per commit, no resp until new request.
- Aliasing: write 0x0000_0020 then read 0x0000_2020 (DEPTH_LINES=256) -> identical data; low address bits 0x0000_003F read same line as 0x0000_0020.
- mem_read and mem_write both high in IDLE -> read burst performed, store unchanged, protocol_err pulses once.
- Initiator drops mem_read during WAIT -> burst still 4 beats, protocol_err one pulse; next request accepted only after DONE.
- Back-to-back reads held high continuously to lines 1 and 2 -> second first-beat exactly LATENCY+5 cycles after first first-beat, DONE gap of one resp-low cycle between bursts.

Source files
------------

// File: rtl/pmem_burst_responder_if.sv
// Physical-memory burst port between a CPU-side initiator and a memory responder.
// Requests are held by the master until the last resp beat.
interface pmem_burst_responder_if #(
   parameter int DATA_W = 64
);
   logic              mem_read;
   logic              mem_write;
   logic [31:0]       mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_resp;
   logic              protocol_err;

   modport master (
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata, mem_resp, protocol_err
   );

   modport slave (
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata, mem_resp, protocol_err
   );
endinterface

// File: rtl/pmem_burst_responder.sv
// Memory-side responder: accepts one cache-line request, waits a fixed latency,
// then moves the line as a BURST_LEN-beat burst to or from a line-organized store.
module pmem_burst_responder #(
   parameter int DATA_W      = 64,
   parameter int BURST_LEN   = 4,
   parameter int DEPTH_LINES = 256,
   parameter int LATENCY     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   pmem_burst_responder_if.slave bus
);
   localparam int LINE_W = $clog2(DEPTH_LINES);
   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int CNT_W  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam int WORD_W = LINE_W + BEAT_W;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic                wr_op_q, wr_op_d;
   logic [CNT_W-1:0]    lat_q, lat_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic                resp_q, resp_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                dropped_q, dropped_d;

   logic                req_held;
   logic                rd_en;
   logic                wr_en;
   logic [WORD_W-1:0]   rd_addr;
   logic [WORD_W-1:0]   wr_addr;

   logic [DATA_W-1:0]   store [DEPTH_LINES*BURST_LEN];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         line_q    <= '0;
         wr_op_q   <= 1'b0;
         lat_q     <= '0;
         beat_q    <= '0;
         resp_q    <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         line_q    <= line_d;
         wr_op_q   <= wr_op_d;
         lat_q     <= lat_d;
         beat_q    <= beat_d;
         resp_q    <= resp_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         dropped_q <= dropped_d;
      end
   end

   // The request line that must stay high is the one matching the latched op.
   assign req_held = wr_op_q ? bus.mem_write : bus.mem_read;

   always_comb begin
      state_d   = state_q;
      line_d    = line_q;
      wr_op_d   = wr_op_q;
      lat_d     = lat_q;
      beat_d    = beat_q;
      resp_d    = 1'b0;
      err_d     = 1'b0;
      dropped_d = dropped_q;
      wr_en     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.mem_read || bus.mem_write) begin
               line_d    = bus.mem_addr[5 +: LINE_W];
               wr_op_d   = bus.mem_write && !bus.mem_read;
               err_d     = bus.mem_read && bus.mem_write;
               dropped_d = 1'b0;
               beat_d    = '0;
               if (LATENCY == 1) begin
                  state_d = S_BURST;
                  resp_d  = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  lat_d   = CNT_W'(LATENCY - 2);
               end
            end
         end
         S_WAIT: begin
            if (!req_held && !dropped_q) begin
               err_d     = 1'b1;
               dropped_d = 1'b1;
            end
            if (lat_q == '0) begin
               state_d = S_BURST;
               beat_d  = '0;
               resp_d  = 1'b1;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         S_BURST: begin
            if (!req_held && !dropped_q) begin
               err_d     = 1'b1;
               dropped_d = 1'b1;
            end
            wr_en = wr_op_q;
            if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
               state_d = S_DONE;
            end else begin
               beat_d = beat_q + 1'b1;
               resp_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Read word for the beat about to be presented is fetched one edge early.
      rd_en   = (state_d == S_BURST) && !wr_op_d;
      rd_addr = {line_d, beat_d};
      wr_addr = {line_q, beat_q};
      rdata_d = rd_en ? store[rd_addr] : '0;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         store[wr_addr] <= bus.mem_wdata;
      end
   end

   assign bus.mem_resp     = resp_q;
   assign bus.mem_rdata    = rdata_q;
   assign bus.protocol_err = err_q;
endmodule

// File: tb/tb_pmem_burst_responder.sv
// Bench for pmem_burst_responder: vector table of line requests checked against a
// line-store model, plus hand sequences for back-to-back and reset-abort cases.
module tb_pmem_burst_responder;
   localparam int LATENCY = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;

   pmem_burst_responder_if #(.DATA_W(64)) bus ();

   pmem_burst_responder #(
      .DATA_W(64), .BURST_LEN(4), .DEPTH_LINES(256), .LATENCY(LATENCY)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          care;
      logic [63:0] d;
   } exp_t;

   typedef struct {
      bit              wr;
      bit              both;
      logic [31:0]     addr;
      logic [3:0][63:0] d;
      int              drop;
      bit              exp_err;
      string           name;
   } vec_t;

   exp_t        exp_q[$];
   logic [63:0] wq[$];
   logic [63:0] model_mem [int];
   int n_vec = 0, n_err = 0;
   int beats_seen = 0, err_cnt = 0, first_cyc = 0;
   bit prev_resp = 1'b0;
   vec_t vt[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model_rd(input int line, input int k);
      int idx;
      idx = line * 4 + k;
      if (model_mem.exists(idx)) return model_mem[idx];
      return '0;
   endfunction

   function automatic vec_t mk(input bit wr, input bit both, input logic [31:0] addr,
                               input logic [63:0] base, input int drop, input bit e,
                               input string name);
      vec_t v;
      v.wr = wr; v.both = both; v.addr = addr; v.drop = drop; v.exp_err = e; v.name = name;
      for (int k = 0; k < 4; k++) v.d[k] = base * 64'(k + 1);
      return v;
   endfunction

   // Monitor: pops scoreboard on every resp beat and supplies write data for that beat.
   always @(negedge clk) begin
      exp_t e;
      if (bus.mem_resp) begin
         if (!prev_resp) first_cyc = cyc;
         if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_beat: got resp=1 rdata=%h expected resp=0", bus.mem_rdata);
         end else begin
            e = exp_q.pop_front();
            if (e.care) check("beat_rdata", bus.mem_rdata, e.d);
         end
         bus.mem_wdata = (wq.size() > 0) ? wq.pop_front() : {$urandom, $urandom};
         beats_seen++;
      end else begin
         check("idle_rdata", bus.mem_rdata, 64'd0);
      end
      if (bus.protocol_err) err_cnt++;
      prev_resp = bus.mem_resp;
   end

   task automatic do_req(input bit wr, input bit both, input logic [31:0] addr,
                         input logic [3:0][63:0] d, input int drop, input bit hold,
                         input int exp_lat, input int abort_at, input bit exp_err,
                         input string name, output int fc);
      int start_beats, start_err, drive_cyc, c, line;
      bit rd_op, aborted;
      exp_t e;
      line  = int'(addr[12:5]);
      rd_op = !wr || both;
      for (int k = 0; k < 4; k++) begin
         e.care = rd_op;
         e.d    = rd_op ? model_rd(line, k) : 64'd0;
         exp_q.push_back(e);
         if (!rd_op) wq.push_back(d[k]);
      end
      start_beats = beats_seen;
      start_err   = err_cnt;
      drive_cyc   = cyc;
      bus.mem_addr  = addr;
      bus.mem_read  = rd_op;
      bus.mem_write = wr;
      c = 0;
      aborted = 1'b0;
      while (beats_seen - start_beats < 4) begin
         if (abort_at > 0 && beats_seen - start_beats >= abort_at) begin
            aborted = 1'b1;
            break;
         end
         @(posedge clk); #1;
         c++;
         if (c == drop) begin
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
         end
         if (c > 40) begin
            n_vec++; n_err++;
            $display("FAIL timeout_%s: got %0d beats expected 4", name, beats_seen - start_beats);
            break;
         end
      end
      fc = first_cyc;
      if (aborted) begin
         rst = 1'b0;
         #1;
         check({"rst_resp_", name}, 64'(bus.mem_resp), 64'd0);
         check({"rst_rdata_", name}, bus.mem_rdata, 64'd0);
         check({"rst_err_", name}, 64'(bus.protocol_err), 64'd0);
         exp_q.delete();
         wq.delete();
         bus.mem_read  = 1'b0;
         bus.mem_write = 1'b0;
         if (wr && !both)
            for (int k = 0; k < abort_at; k++) model_mem[line * 4 + k] = d[k];
         repeat (2) @(posedge clk);
         #1;
         rst = 1'b1;
         for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check({"post_rst_resp_", name}, 64'(bus.mem_resp), 64'd0);
         end
      end else begin
         if (wr && !both)
            for (int k = 0; k < 4; k++) model_mem[line * 4 + k] = d[k];
         check({"lat_", name}, 64'(first_cyc - drive_cyc), 64'(exp_lat));
         check({"err_", name}, 64'(err_cnt - start_err), 64'(exp_err));
         $display("req %-10s addr=%h wr=%0b both=%0b first_beat_lat=%0d err_pulses=%0d",
                  name, addr, wr, both, first_cyc - drive_cyc, err_cnt - start_err);
         if (!hold) begin
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      int fc1, fc2, fc;
      logic [3:0][63:0] d_e;

      vt[0]  = mk(1, 0, 32'h0000_0040, 64'h1111_1111_1111_1111, 0, 0, "wr_40");
      vt[1]  = mk(0, 0, 32'h0000_0040, 64'h0, 0, 0, "rd_40");
      vt[2]  = mk(1, 0, 32'h0000_0020, 64'h0A5A_0F0F_1234_5678, 0, 0, "wr_20");
      vt[3]  = mk(0, 0, 32'h0000_2020, 64'h0, 0, 0, "rd_alias");
      vt[4]  = mk(0, 0, 32'h0000_003F, 64'h0, 0, 0, "rd_3f");
      vt[5]  = mk(1, 1, 32'h0000_0040, 64'hDEAD_BEEF_0000_0001, 0, 1, "both_40");
      vt[6]  = mk(0, 0, 32'h0000_0040, 64'h0, 0, 0, "rd_40_chk");
      vt[7]  = mk(1, 0, 32'h0000_0060, 64'h0C0C_0000_C0C0_0003, 0, 0, "wr_60");
      vt[8]  = mk(0, 0, 32'h0000_0060, 64'h0, 1, 1, "rd_drop");
      vt[9]  = mk(0, 0, 32'h0000_0020, 64'h0, 0, 0, "rd_after");
      vt[10] = mk(1, 0, 32'h0000_0060, 64'h0D0D_5555_0000_0007, 5, 1, "wr_drop");
      vt[11] = mk(0, 0, 32'h0000_0060, 64'h0, 0, 0, "rd_60_chk");

      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;

      #2;
      check("reset_resp", 64'(bus.mem_resp), 64'd0);
      check("reset_rdata", bus.mem_rdata, 64'd0);
      check("reset_err", 64'(bus.protocol_err), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++)
         do_req(vt[i].wr, vt[i].both, vt[i].addr, vt[i].d, vt[i].drop, 1'b0,
                LATENCY, 0, vt[i].exp_err, vt[i].name, fc);

      // Back-to-back reads with mem_read held through DONE.
      do_req(0, 0, 32'h0000_0020, '0, 0, 1'b1, LATENCY, 0, 0, "b2b_1", fc1);
      do_req(0, 0, 32'h0000_0040, '0, 0, 1'b0, LATENCY + 1, 0, 0, "b2b_2", fc2);
      check("b2b_spacing", 64'(fc2 - fc1), 64'(LATENCY + 5));

      // Reset during a read burst after beat 1.
      do_req(0, 0, 32'h0000_0040, '0, 0, 1'b0, LATENCY, 2, 0, "rst_rd", fc);
      do_req(0, 0, 32'h0000_0040, '0, 0, 1'b0, LATENCY, 0, 0, "rd_post_rst", fc);

      // Reset during a write burst: beats 0 and 1 committed, 2 and 3 keep old data.
      for (int k = 0; k < 4; k++) d_e[k] = 64'hE0E0_0000_0000_0000 | 64'(k);
      do_req(1, 0, 32'h0000_0020, d_e, 0, 1'b0, LATENCY, 2, 0, "rst_wr", fc);
      do_req(0, 0, 32'h0000_0020, '0, 0, 1'b0, LATENCY, 0, 0, "rd_partial", fc);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
